// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM encodings and burst counter width.
// Optional build macro FIFO_ARB_PRIO_EN is consumed by rr_pick.
package fifo_wr_arbiter_pkg;

   localparam int unsigned CNT_W = 4;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } state_t;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req index starting at ptr+1 mod NREQ.
// With FIFO_ARB_PRIO_EN defined, req[0] always wins the pick.
module rr_pick #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic            found,
   output logic [IW-1:0]   idx
);

   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = 1; i <= int'(NREQ); i++) begin
         if (!found && req[(int'(ptr) + i) % int'(NREQ)]) begin
            found = 1'b1;
            idx   = IW'((int'(ptr) + i) % int'(NREQ));
         end
      end
`ifdef FIFO_ARB_PRIO_EN
      if (req[0]) begin
         found = 1'b1;
         idx   = '0;
      end
`endif
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NREQ requesters with burst locking.
// Build macro FIFO_ARB_PRIO_EN gives requester 0 priority at each arbitration.
module fifo_wr_arbiter
   import fifo_wr_arbiter_pkg::*;
#(
   parameter int unsigned B        = 8,
   parameter int unsigned NREQ     = 4,
   parameter int unsigned IW       = 2,
   parameter int unsigned MAXBURST = 4
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ*B-1:0] w_data_in,
   output logic [NREQ-1:0] ack,
   output logic            fifo_wr,
   output logic [B-1:0]    fifo_w_data,
   input  logic            fifo_full,
   output logic [IW-1:0]   owner,
   output logic            busy
);

   state_t           state_q, state_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [IW-1:0]    owner_q, owner_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             found;
   logic [IW-1:0]    idx;
   logic             xfer;
   logic             release_lock;

   rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_rr_pick (
      .req   (req),
      .ptr   (ptr_q),
      .found (found),
      .idx   (idx)
   );

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      owner_d      = owner_q;
      cnt_d        = cnt_q;
      ack          = '0;
      release_lock = 1'b0;
      // Writes are suppressed while RESET is high so an aborted burst never lands in the FIFO.
      xfer         = (state_q == ST_LOCK) && req[owner_q] && !fifo_full && !RESET;
      fifo_wr      = xfer;
      fifo_w_data  = w_data_in[owner_q*B +: B];
      busy         = (state_q == ST_LOCK);
      owner        = owner_q;

      unique case (state_q)
         ST_IDLE: begin
            if (found) begin
               owner_d = idx;
               cnt_d   = '0;
               state_d = ST_LOCK;
            end
         end
         ST_LOCK: begin
            if (!req[owner_q]) begin
               release_lock = 1'b1;
            end else if (xfer) begin
               ack[owner_q] = 1'b1;
               cnt_d        = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(MAXBURST - 1)) begin
                  release_lock = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (release_lock) begin
         state_d = ST_IDLE;
`ifdef FIFO_ARB_PRIO_EN
         // Requester 0 bursts leave ptr alone so 1..NREQ-1 keep their rotation.
         if (owner_q != '0) begin
            ptr_d = owner_q;
         end
`else
         ptr_d = owner_q;
`endif
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         ptr_q   <= IW'(NREQ - 1);
         owner_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (B=8, NREQ=4, MAXBURST=4).
// Honours FIFO_ARB_PRIO_EN for the priority-order scenario.
module tb_fifo_wr_arbiter;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [3:0]  req;
   logic [31:0] w_data_in;
   logic [3:0]  ack;
   logic        fifo_wr;
   logic [7:0]  fifo_w_data;
   logic        fifo_full;
   logic [1:0]  owner;
   logic        busy;

   int checks = 0;
   int errors = 0;

   fifo_wr_arbiter #(
      .B        (8),
      .NREQ     (4),
      .IW       (2),
      .MAXBURST (4)
   ) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .req         (req),
      .w_data_in   (w_data_in),
      .ack         (ack),
      .fifo_wr     (fifo_wr),
      .fifo_w_data (fifo_w_data),
      .fifo_full   (fifo_full),
      .owner       (owner),
      .busy        (busy)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      req       = 4'b1111;
      w_data_in = 32'h44_33_22_11;
      fifo_full = 1'b0;
      RESET     = 1'b1;
      for (int c = 0; c < 2; c++) begin
         step();
         checks++;
         if (ack !== 4'b0000 || fifo_wr !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs cyc%0d: ack=%b wr=%b busy=%b, want 0000/0/0",
                     c, ack, fifo_wr, busy);
         end
      end
      RESET = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || fifo_wr !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: busy=%b wr=%b, want 0/0", busy, fifo_wr);
      end
      for (int c = 0; c < 4; c++) begin
         step();
         checks++;
         if (busy !== 1'b1 || owner !== 2'd0 || fifo_wr !== 1'b1 || ack !== 4'b0001
             || fifo_w_data !== 8'h11) begin
            errors++;
            $display("FAIL reset_first_burst w%0d: busy=%b owner=%0d wr=%b ack=%b data=%h, want 1/0/1/0001/11",
                     c, busy, owner, fifo_wr, ack, fifo_w_data);
         end
      end
      step();
      checks++;
      if (busy !== 1'b0 || fifo_wr !== 1'b0) begin
         errors++;
         $display("FAIL reset_bubble: busy=%b wr=%b, want 0/0", busy, fifo_wr);
      end
      step();
      checks++;
      if (busy !== 1'b1 || owner !== 2'd1 || ack !== 4'b0010 || fifo_w_data !== 8'h22) begin
         errors++;
         $display("FAIL reset_second_owner: busy=%b owner=%0d ack=%b data=%h, want 1/1/0010/22",
                  busy, owner, ack, fifo_w_data);
      end
   endtask

   task automatic test_data_integrity();
      logic       exp_wr;
      logic [7:0] exp_data;
      logic [3:0] exp_ack;
      fifo_full = 1'b0;
      req       = 4'b0000;
      w_data_in = 32'hC3_5A_A1_3C;
      do_reset();
      req = 4'b1010;
      #1;
      for (int c = 0; c < 15; c++) begin
         exp_wr   = (c % 5) != 0;
         exp_data = ((c / 5) % 2 == 0) ? 8'hA1 : 8'hC3;
         exp_ack  = !exp_wr ? 4'b0000 : (((c / 5) % 2 == 0) ? 4'b0010 : 4'b1000);
         checks++;
         if (fifo_wr !== exp_wr || ack !== exp_ack || (exp_wr && fifo_w_data !== exp_data)) begin
            errors++;
            $display("FAIL data_seq c%0d: wr=%b ack=%b data=%h, want %b/%b/%h",
                     c, fifo_wr, ack, fifo_w_data, exp_wr, exp_ack, exp_data);
         end
         step();
      end
   endtask

   task automatic test_full_stall();
      int writes;
      fifo_full = 1'b0;
      req       = 4'b0000;
      w_data_in = 32'h00_77_00_00;
      do_reset();
      req = 4'b0100;
      step();
      step();
      fifo_full = 1'b1;
      #1;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (fifo_wr !== 1'b0 || ack !== 4'b0000 || busy !== 1'b1 || owner !== 2'd2) begin
            errors++;
            $display("FAIL stall_c%0d: wr=%b ack=%b busy=%b owner=%0d, want 0/0000/1/2",
                     c, fifo_wr, ack, busy, owner);
         end
         step();
      end
      fifo_full = 1'b0;
      #1;
      writes = 0;
      for (int c = 0; c < 6 && busy === 1'b1; c++) begin
         if (fifo_wr === 1'b1) writes++;
         step();
      end
      checks++;
      if (writes !== 3 || busy !== 1'b0) begin
         errors++;
         $display("FAIL stall_resume: writes=%0d busy=%b, want 3/0", writes, busy);
      end
   endtask

   task automatic test_early_drop();
      fifo_full = 1'b0;
      req       = 4'b0000;
      w_data_in = 32'h44_33_22_11;
      do_reset();
      req = 4'b0010;
      step();
      step();
      step();
      req = 4'b1101;
      #1;
      checks++;
      if (fifo_wr !== 1'b0 || ack !== 4'b0000 || busy !== 1'b1) begin
         errors++;
         $display("FAIL drop_cycle: wr=%b ack=%b busy=%b, want 0/0000/1", fifo_wr, ack, busy);
      end
      step();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL drop_release: busy=%b, want 0", busy);
      end
      step();
      checks++;
      if (busy !== 1'b1 || owner !== 2'd2 || ack !== 4'b0100) begin
         errors++;
         $display("FAIL drop_next_owner: busy=%b owner=%0d ack=%b, want 1/2/0100", busy, owner, ack);
      end
   endtask

   task automatic test_reset_mid_lock();
      fifo_full = 1'b0;
      req       = 4'b0000;
      w_data_in = 32'h44_33_22_11;
      do_reset();
      req = 4'b1000;
      step();
      step();
      step();
      checks++;
      if (busy !== 1'b1 || owner !== 2'd3 || fifo_wr !== 1'b1) begin
         errors++;
         $display("FAIL midreset_setup: busy=%b owner=%0d wr=%b, want 1/3/1", busy, owner, fifo_wr);
      end
      RESET = 1'b1;
      #1;
      checks++;
      if (fifo_wr !== 1'b0 || ack !== 4'b0000) begin
         errors++;
         $display("FAIL midreset_abort: wr=%b ack=%b, want 0/0000", fifo_wr, ack);
      end
      step();
      RESET = 1'b0;
      req   = 4'b0110;
      #1;
      checks++;
      if (busy !== 1'b0 || fifo_wr !== 1'b0) begin
         errors++;
         $display("FAIL midreset_idle: busy=%b wr=%b, want 0/0", busy, fifo_wr);
      end
      step();
      checks++;
      if (busy !== 1'b1 || owner !== 2'd1) begin
         errors++;
         $display("FAIL midreset_regrant: busy=%b owner=%0d, want 1/1", busy, owner);
      end
   endtask

   task automatic test_prio_order();
      logic [1:0] exp_owner [3];
`ifdef FIFO_ARB_PRIO_EN
      exp_owner = '{2'd2, 2'd0, 2'd3};
`else
      exp_owner = '{2'd2, 2'd3, 2'd0};
`endif
      fifo_full = 1'b0;
      req       = 4'b0000;
      w_data_in = 32'h44_33_22_11;
      do_reset();
      req = 4'b0100;
      step();
      req = 4'b1101;
      #1;
      for (int b = 0; b < 3; b++) begin
         checks++;
         if (busy !== 1'b1 || owner !== exp_owner[b]) begin
            errors++;
            $display("FAIL order_burst%0d: busy=%b owner=%0d, want 1/%0d",
                     b, busy, owner, exp_owner[b]);
         end
         if (b < 2) begin
            for (int c = 0; c < 5; c++) step();
         end
      end
   endtask

   initial begin
      RESET     = 1'b1;
      req       = '0;
      w_data_in = '0;
      fifo_full = 1'b0;
      test_reset();
      test_data_integrity();
      test_full_stall();
      test_early_drop();
      test_reset_mid_lock();
      test_prio_order();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
